// File: rtl/fpu_arb_pkg.sv
// Shared types and helpers for the sqrt-unit arbiter.
package fpu_arb_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned NREQ_DEF = 2;
  // Upper bound on requester count supported by the round-robin search
  localparam int unsigned MAX_REQ  = 32;
  localparam int unsigned IDX_W    = 5;

  // In-flight operand tag for the default requester count
  typedef struct packed {
    logic                            valid;
    logic [$clog2(NREQ_DEF)-1:0]     id;
  } tag_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of elig[n-1:0] scanning upward from ptr with wrap-around (ptr < n)
  function automatic rr_pick_t rr_search(input logic [MAX_REQ-1:0] elig,
                                         input int unsigned ptr,
                                         input int unsigned n);
    rr_pick_t    pick;
    int unsigned idx;
    pick = '0;
    for (int unsigned off = 0; off < MAX_REQ; off++) begin
      idx = ptr + off;
      if (idx >= n) idx = idx - n;
      if (off < n && !pick.found && elig[idx[IDX_W-1:0]]) begin
        pick.found = 1'b1;
        pick.idx   = idx[IDX_W-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fpu_res_fifo.sv
// Synchronous result FIFO; head word reads as zero while empty.
module fpu_res_fifo
  import fpu_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CntW'(DEPTH));
  assign empty   = (cnt_q == '0);
  // Push into a full FIFO is only legal when the head leaves on the same edge
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem_q[rd_q];

  // Pointer and occupancy next-state
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = (wr_q == PtrW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
    if (do_pop)  rd_d = (rd_q == PtrW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy state
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

  // Credits upstream must make an overflowing write impossible
  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn) !(push && full && !pop));

endmodule

// File: rtl/fpu_sqrt_arbiter.sv
// Round-robin arbiter sharing one non-stallable pipelined sqrt unit between NREQ requesters.
// Results are steered back by a tag shift register into per-requester FIFOs; credits
// (one per FIFO slot) keep the unit from ever producing a result with nowhere to go.
// Optional: define FPU_SQRT_ARB_STATS_EN to add per-requester issue/stall counters.
module fpu_sqrt_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int unsigned NSTAGE    = 4,
  parameter int unsigned NREQ      = 2,
  parameter int unsigned RES_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WORD_W-1:0]   req_x,
  output logic [WORD_W-1:0]        fu_x,
  input  logic [WORD_W-1:0]        fu_y,
  output logic [NREQ-1:0]          res_valid,
  input  logic [NREQ-1:0]          res_ready,
  output logic [NREQ*WORD_W-1:0]   res_y,
  output logic                     busy
`ifdef FPU_SQRT_ARB_STATS_EN
  ,
  output logic [NREQ*WORD_W-1:0]   stat_issue,
  output logic [NREQ*WORD_W-1:0]   stat_stall
`endif
);

  localparam int unsigned IdW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW = $clog2(RES_DEPTH + 1);

  typedef struct packed {
    logic           valid;
    logic [IdW-1:0] id;
  } arb_tag_t;

  arb_tag_t            tag_q [NSTAGE+1];
  logic [IdW-1:0]      ptr_q, ptr_d;
  logic [WORD_W-1:0]   fu_x_q;
  logic [CntW-1:0]     credit_q [NREQ];
  logic [CntW-1:0]     credit_d [NREQ];
  logic [MAX_REQ-1:0]  elig;
  rr_pick_t            pick;
  logic                accept;
  logic [IdW-1:0]      acc_id;
  logic [WORD_W-1:0]   sel_x;
  logic [NREQ-1:0]     grant, pop, push, fifo_full, fifo_empty;
  logic                unused_sink;

  // A requester competes only while it holds a credit for a free result slot
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      elig[i] = req_valid[i] && (credit_q[i] != '0);
    end
  end

  assign pick = rr_search(elig, 32'(ptr_q), NREQ);

  // Grant decode, operand select and next round-robin pointer
  always_comb begin
    accept = rstn && pick.found;
    acc_id = pick.idx[IdW-1:0];
    grant  = '0;
    sel_x  = '0;
    ptr_d  = ptr_q;
    if (accept) begin
      grant[acc_id] = 1'b1;
      ptr_d = (acc_id == IdW'(NREQ - 1)) ? '0 : acc_id + 1'b1;
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) sel_x = req_x[i*WORD_W +: WORD_W];
    end
  end

  assign req_ready = grant;
  assign fu_x      = fu_x_q;
  assign pop       = res_valid & res_ready;

  // Credit bookkeeping: grant takes a slot, pop returns one, both together cancel
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      case ({grant[i], pop[i]})
        2'b10:   credit_d[i] = credit_q[i] - CntW'(1);
        2'b01:   credit_d[i] = credit_q[i] + CntW'(1);
        default: credit_d[i] = credit_q[i];
      endcase
    end
  end

  // Route the unit output to the owner of the operand leaving the pipeline
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      push[i] = tag_q[NSTAGE].valid && (tag_q[NSTAGE].id == IdW'(i));
    end
  end

  // Operand register, tag pipeline, pointer and credits
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fu_x_q <= '0;
      ptr_q  <= '0;
      for (int unsigned k = 0; k <= NSTAGE; k++) tag_q[k] <= '0;
      for (int unsigned i = 0; i < NREQ; i++) credit_q[i] <= CntW'(RES_DEPTH);
    end else begin
      if (accept) fu_x_q <= sel_x;
      ptr_q    <= ptr_d;
      tag_q[0] <= '{valid: accept, id: acc_id};
      for (int unsigned k = 1; k <= NSTAGE; k++) tag_q[k] <= tag_q[k-1];
      for (int unsigned i = 0; i < NREQ; i++) credit_q[i] <= credit_d[i];
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_fifo
    fpu_res_fifo #(
      .DEPTH (RES_DEPTH),
      .WIDTH (WORD_W)
    ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push[g]),
      .wdata (fu_y),
      .pop   (pop[g]),
      .rdata (res_y[g*WORD_W +: WORD_W]),
      .full  (fifo_full[g]),
      .empty (fifo_empty[g])
    );
  end

  assign res_valid = ~fifo_empty;

  // Busy while any operand is in the unit or any result waits to be popped
  always_comb begin
    busy = |res_valid;
    for (int unsigned k = 0; k <= NSTAGE; k++) busy = busy | tag_q[k].valid;
  end

  // Full flags are redundant with credits; upper index bits unused for small NREQ
  assign unused_sink = ^{fifo_full, pick.idx};

`ifdef FPU_SQRT_ARB_STATS_EN
  logic [WORD_W-1:0] issue_q [NREQ];
  logic [WORD_W-1:0] stall_q [NREQ];
  logic [NREQ-1:0]   stall;

  assign stall = req_valid & ~req_ready;

  // Free-running per-requester issue and stall counters, wrapping naturally
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        issue_q[i] <= '0;
        stall_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (grant[i]) issue_q[i] <= issue_q[i] + 1'b1;
        if (stall[i]) stall_q[i] <= stall_q[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_stat
    assign stat_issue[g*WORD_W +: WORD_W] = issue_q[g];
    assign stat_stall[g*WORD_W +: WORD_W] = stall_q[g];
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fpu_sqrt_arbiter.sv
// Bench for fpu_sqrt_arbiter: directed scenarios plus random traffic against a
// transaction-level model (credits, round-robin order, latency, per-requester queues).
module tb_fpu_sqrt_arbiter;

  localparam int unsigned NSTAGE    = 4;
  localparam int unsigned NREQ      = 2;
  localparam int unsigned RES_DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*32-1:0]   req_x = '0;
  logic [31:0]          fu_x, fu_y;
  logic [NREQ-1:0]      res_valid;
  logic [NREQ-1:0]      res_ready = '0;
  logic [NREQ*32-1:0]   res_y;
  logic                 busy;
`ifdef FPU_SQRT_ARB_STATS_EN
  logic [NREQ*32-1:0]   stat_issue, stat_stall;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fpu_sqrt_arbiter #(
    .NSTAGE    (NSTAGE),
    .NREQ      (NREQ),
    .RES_DEPTH (RES_DEPTH)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .fu_x       (fu_x),
    .fu_y       (fu_y),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_y      (res_y),
    .busy       (busy)
`ifdef FPU_SQRT_ARB_STATS_EN
    ,
    .stat_issue (stat_issue),
    .stat_stall (stat_stall)
`endif
  );

  // Stand-in sqrt unit: exact for the directed operands, a fixed scramble otherwise
  function automatic logic [31:0] unit_f(input logic [31:0] x);
    case (x)
      32'h4080_0000: return 32'h4000_0000;
      32'h4110_0000: return 32'h4040_0000;
      32'h4180_0000: return 32'h4080_0000;
      32'h4000_0000: return 32'h3FB5_04F3;
      default:       return {x[15:0], x[31:16]} ^ 32'h5A5A_A5A5;
    endcase
  endfunction

  logic [31:0] fu_pipe [NSTAGE];
  always @(posedge clk) begin
    fu_pipe[0] <= unit_f(fu_x);
    for (int k = 1; k < NSTAGE; k++) fu_pipe[k] <= fu_pipe[k-1];
  end
  assign fu_y = fu_pipe[NSTAGE-1];

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    int          id;
    logic [31:0] val;
    int          due;
  } fl_t;

  fl_t             m_fl[$];
  fl_t             m_tmp;
  logic [31:0]     m_q [NREQ][$];
  logic [31:0]     m_dummy;
  int              m_credit [NREQ];
  int              m_ptr = 0;
  int              cyc = 0;
  int              m_idx;
  int              m_win;
  logic [NREQ-1:0] exp_rdy;
  logic            exp_busy;

  // Inputs change 1 time unit after posedge, so at negedge they show what the next edge takes
  always @(negedge clk) begin
    cyc++;
    while (m_fl.size() > 0 && m_fl[0].due <= cyc) begin
      m_tmp = m_fl.pop_front();
      m_q[m_tmp.id].push_back(m_tmp.val);
    end
    exp_rdy = '0;
    m_win   = -1;
    if (rstn) begin
      for (int off = 0; off < NREQ; off++) begin
        m_idx = (m_ptr + off) % NREQ;
        if (m_win < 0 && req_valid[m_idx] && m_credit[m_idx] > 0) m_win = m_idx;
      end
      if (m_win >= 0) exp_rdy[m_win] = 1'b1;
    end
    total++;
    if (req_ready !== exp_rdy) begin
      bad++;
      $display("FAIL mon_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_rdy);
    end
    exp_busy = (m_fl.size() > 0);
    for (int i = 0; i < NREQ; i++) begin
      if (m_q[i].size() > 0) exp_busy = 1'b1;
      total++;
      if (res_valid[i] !== (m_q[i].size() > 0)) begin
        bad++;
        $display("FAIL mon_res_valid[%0d] cyc=%0d got=%b exp=%b", i, cyc, res_valid[i],
                 m_q[i].size() > 0);
      end else if (m_q[i].size() > 0) begin
        total++;
        if (res_y[i*32 +: 32] !== m_q[i][0]) begin
          bad++;
          $display("FAIL mon_res_y[%0d] cyc=%0d got=%h exp=%h", i, cyc, res_y[i*32 +: 32],
                   m_q[i][0]);
        end
      end
    end
    total++;
    if (busy !== exp_busy) begin
      bad++;
      $display("FAIL mon_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
    end
    if (!rstn) begin
      m_fl.delete();
      for (int i = 0; i < NREQ; i++) begin
        m_q[i].delete();
        m_credit[i] = RES_DEPTH;
      end
      m_ptr = 0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (m_q[i].size() > 0 && res_ready[i]) begin
          m_dummy = m_q[i].pop_front();
          m_credit[i]++;
        end
      end
      if (m_win >= 0) begin
        m_credit[m_win]--;
        m_ptr = (m_win + 1) % NREQ;
        m_fl.push_back('{id: m_win, val: unit_f(req_x[m_win*32 +: 32]),
                         due: cyc + NSTAGE + 2});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstn = 1'b0;
    req_valid = '1;
    res_ready = '0;
    step();
    step();
    @(negedge clk);
    total++;
    if (req_ready !== '0) begin bad++; $display("FAIL rst_ready got=%b exp=0", req_ready); end
    total++;
    if (res_valid !== '0) begin bad++; $display("FAIL rst_res_valid got=%b exp=0", res_valid); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++;
    if (fu_x !== 32'h0) begin bad++; $display("FAIL rst_fu_x got=%h exp=0", fu_x); end
    total++;
    if (res_y !== '0) begin bad++; $display("FAIL rst_res_y got=%h exp=0", res_y); end
    step();
    req_valid = '0;
    rstn = 1'b1;
    step();
  endtask

  task automatic test_single();
    bit got = 0;
    int lat = 0;
    req_x[31:0] = 32'h4080_0000;
    req_valid   = 2'b01;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[0]) begin got = 1; break; end
    end
    total++;
    if (!got) begin bad++; $display("FAIL single_accept got=timeout exp=grant"); end
    step();
    req_valid = '0;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (res_valid[0]) begin got = 1; break; end
    end
    total++;
    if (!got || lat != NSTAGE + 1) begin
      bad++;
      $display("FAIL single_latency got=%0d exp=%0d", lat, NSTAGE + 1);
    end
    total++;
    if (res_y[31:0] !== 32'h4000_0000) begin
      bad++;
      $display("FAIL single_data got=%h exp=40000000", res_y[31:0]);
    end
    total++;
    if (res_valid[1] !== 1'b0) begin bad++; $display("FAIL single_other got=1 exp=0"); end
    step();
    res_ready = 2'b01;
    step();
    res_ready = '0;
    step();
  endtask

  task automatic test_contention();
    int cnt [NREQ] = '{0, 0};
    logic [NREQ-1:0] exp_g;
    req_x     = {32'h4180_0000, 32'h4110_0000};
    req_valid = 2'b11;
    res_ready = 2'b11;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k < 8) begin
        // The previous test's single grant left the pointer at requester 1
        exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
        total++;
        if (req_ready !== exp_g) begin
          bad++;
          $display("FAIL contention_grant k=%0d got=%b exp=%b", k, req_ready, exp_g);
        end
      end
      if (res_valid[0] && res_ready[0]) begin
        cnt[0]++;
        total++;
        if (res_y[31:0] !== 32'h4040_0000) begin
          bad++;
          $display("FAIL contention_y0 got=%h exp=40400000", res_y[31:0]);
        end
      end
      if (res_valid[1] && res_ready[1]) begin
        cnt[1]++;
        total++;
        if (res_y[63:32] !== 32'h4080_0000) begin
          bad++;
          $display("FAIL contention_y1 got=%h exp=40800000", res_y[63:32]);
        end
      end
      step();
      if (k == 7) req_valid = '0;
    end
    for (int i = 0; i < NREQ; i++) begin
      total++;
      if (cnt[i] != 4) begin
        bad++;
        $display("FAIL contention_count[%0d] got=%0d exp=4", i, cnt[i]);
      end
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL contention_idle got=%b exp=0", busy); end
  endtask

  task automatic test_credit();
    int n = 0;
    res_ready   = '0;
    req_x       = {32'h4180_0000, 32'h4110_0000};
    req_valid   = 2'b01;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (req_ready[0]) n++;
      if (k == 11) begin
        total++;
        if (req_ready[0] !== 1'b0) begin bad++; $display("FAIL credit_masked got=1 exp=0"); end
      end
      step();
    end
    total++;
    if (n != RES_DEPTH) begin
      bad++;
      $display("FAIL credit_accepts got=%0d exp=%0d", n, RES_DEPTH);
    end
    req_valid = 2'b11;
    res_ready = 2'b10;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if (req_ready !== 2'b10) begin
        bad++;
        $display("FAIL credit_other_granted got=%b exp=10", req_ready);
      end
      step();
    end
    req_valid = 2'b01;
    res_ready = 2'b01;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) begin
        total++;
        if (res_valid[0] !== 1'b1) begin bad++; $display("FAIL credit_pop_avail got=0 exp=1"); end
      end
      if (req_ready[0]) n++;
      step();
      res_ready = '0;
    end
    total++;
    if (n != 1) begin bad++; $display("FAIL credit_one_more got=%0d exp=1", n); end
    req_valid = '0;
    res_ready = 2'b11;
    for (int k = 0; k < 40 && busy; k++) step();
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL credit_drain got=%b exp=0", busy); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] got_y [$];
    bit ok = 0;
    res_ready   = 2'b01;
    req_x[31:0] = 32'h4000_0000;
    req_valid   = 2'b01;
    for (int j = 0; j < 2; j++) begin
      ok = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (res_valid[0]) got_y.push_back(res_y[31:0]);
        if (req_ready[0]) begin ok = 1; break; end
        step();
      end
      total++;
      if (!ok) begin bad++; $display("FAIL b2b_accept%0d got=timeout exp=grant", j); end
      step();
      req_x[31:0] = 32'h4080_0000;
    end
    req_valid = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (res_valid[0]) got_y.push_back(res_y[31:0]);
      step();
    end
    total++;
    if (got_y.size() != 2) begin
      bad++;
      $display("FAIL b2b_count got=%0d exp=2", got_y.size());
    end else begin
      total++;
      if (got_y[0] !== 32'h3FB5_04F3 || got_y[1] !== 32'h4000_0000) begin
        bad++;
        $display("FAIL b2b_order got=%h,%h exp=3fb504f3,40000000", got_y[0], got_y[1]);
      end
    end
  endtask

  task automatic test_reset_midflight();
    int n = 0;
    bit seen = 0;
    res_ready = '0;
    req_x     = {32'h4180_0000, 32'h4110_0000};
    req_valid = 2'b11;
    repeat (3) step();
    req_valid = '0;
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    total++;
    if (res_valid !== '0) begin bad++; $display("FAIL midrst_res_valid got=%b exp=0", res_valid); end
    for (int k = 0; k < 12; k++) begin
      step();
      @(negedge clk);
      if (res_valid !== '0) seen = 1;
    end
    total++;
    if (seen) begin bad++; $display("FAIL midrst_stale got=result exp=none"); end
    step();
    req_valid = 2'b01;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (req_ready[0]) n++;
      step();
    end
    total++;
    if (n != RES_DEPTH) begin
      bad++;
      $display("FAIL midrst_credits got=%0d exp=%0d", n, RES_DEPTH);
    end
    req_valid = '0;
    res_ready = 2'b11;
    for (int k = 0; k < 40 && busy; k++) step();
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL midrst_drain got=%b exp=0", busy); end
    step();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      res_ready = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) req_x[i*32 +: 32] = $urandom;
      step();
    end
    req_valid = '0;
    res_ready = '1;
    for (int k = 0; k < 40 && busy; k++) step();
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || res_valid !== '0) begin
      bad++;
      $display("FAIL random_drain got=busy%b/valid%b exp=0/00", busy, res_valid);
    end
    step();
  endtask

`ifdef FPU_SQRT_ARB_STATS_EN
  task automatic test_stats();
    rstn = 1'b0;
    req_valid = '0;
    step();
    rstn = 1'b1;
    res_ready = 2'b11;
    req_x = {32'h4180_0000, 32'h4110_0000};
    req_valid = 2'b11;
    repeat (10) step();
    req_valid = '0;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      total++;
      if (stat_issue[i*32 +: 32] !== 32'd5) begin
        bad++;
        $display("FAIL stat_issue[%0d] got=%0d exp=5", i, stat_issue[i*32 +: 32]);
      end
      total++;
      if (stat_stall[i*32 +: 32] !== 32'd5) begin
        bad++;
        $display("FAIL stat_stall[%0d] got=%0d exp=5", i, stat_stall[i*32 +: 32]);
      end
    end
    for (int k = 0; k < 40 && busy; k++) step();
    step();
  endtask
`endif

  initial begin
    for (int i = 0; i < NREQ; i++) m_credit[i] = RES_DEPTH;
    test_reset();
    test_single();
    test_contention();
    test_credit();
    test_back_to_back();
    test_reset_midflight();
    test_random();
`ifdef FPU_SQRT_ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
